// File: rtl/fp_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_types_pkg
// Description : Shared floating-point type codes, format widths and helpers
//               used by the element unpacker and the fp9 converter.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_types_pkg;

  localparam logic [4:0] TYPE_FP4  = 5'd0;
  localparam logic [4:0] TYPE_FP8  = 5'd1;
  localparam logic [4:0] TYPE_FP16 = 5'd2;

  localparam int unsigned C_FP4_WIDTH  = 4;
  localparam int unsigned C_FP8_WIDTH  = 8;
  localparam int unsigned C_FP16_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } unpack_state_t;

  // Zero marks an unsupported type code.
  function automatic logic [3:0] elems_per_word(input logic [4:0] i_type);
    case (i_type)
      TYPE_FP4:  elems_per_word = 4'd8;
      TYPE_FP8:  elems_per_word = 4'd4;
      TYPE_FP16: elems_per_word = 4'd2;
      default:   elems_per_word = 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_elem_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : fp_elem_unpacker
// Description : Splits packed 32-bit FP4/FP8/FP16 words into one right-aligned
//               element per cycle with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_elem_unpacker
  import fp_types_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ELEM_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WORD_WIDTH-1:0] in_word_i,
  input  logic [4:0]            in_type_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ELEM_WIDTH-1:0] out_elem_o,
  output logic [4:0]            out_type_o,
  output logic                  out_first_o,
  output logic                  out_last_o,
  output logic                  err_type_o
);

  unpack_state_t         r_state;
  logic [WORD_WIDTH-1:0] r_word;
  logic [4:0]            r_type;
  logic                  r_last;
  logic [2:0]            r_idx;
  logic                  r_err;

  logic                  w_busy;
  logic [2:0]            w_last_idx;
  logic [4:0]            w_shamt;
  logic [ELEM_WIDTH-1:0] w_mask;
  logic [ELEM_WIDTH-1:0] w_sel;
  logic                  w_in_type_ok;
  logic                  w_accept;
  logic                  w_word_done;

  assign w_busy       = (r_state == ST_EMIT);
  assign w_last_idx   = 3'(elems_per_word(r_type) - 4'd1);
  assign w_in_type_ok = (elems_per_word(in_type_i) != 4'd0);
  assign w_word_done  = out_ready_i && (r_idx == w_last_idx);

  // Shift amount is idx * element width, built by concatenation per format.
  always_comb begin
    w_shamt = 5'd0;
    w_mask  = '0;
    case (r_type)
      TYPE_FP4: begin
        w_shamt = {r_idx, 2'b00};
        w_mask  = ELEM_WIDTH'((1 << C_FP4_WIDTH) - 1);
      end
      TYPE_FP8: begin
        w_shamt = {r_idx[1:0], 3'b000};
        w_mask  = ELEM_WIDTH'((1 << C_FP8_WIDTH) - 1);
      end
      TYPE_FP16: begin
        w_shamt = {r_idx[0], 4'b0000};
        w_mask  = ELEM_WIDTH'((1 << C_FP16_WIDTH) - 1);
      end
      default: begin
        w_shamt = 5'd0;
        w_mask  = '0;
      end
    endcase
  end

  assign w_sel = ELEM_WIDTH'(r_word >> w_shamt);

  // Ready never depends on in_valid_i; only on held state and downstream ready.
  assign in_ready_o = !rst_i && (!w_busy || w_word_done);
  assign w_accept   = in_valid_i && in_ready_o;

  assign out_valid_o = w_busy;
  assign out_elem_o  = w_busy ? (w_sel & w_mask) : '0;
  assign out_type_o  = w_busy ? r_type : 5'd0;
  assign out_first_o = w_busy && (r_idx == 3'd0);
  assign out_last_o  = w_busy && r_last && (r_idx == w_last_idx);
  assign err_type_o  = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
      r_type  <= 5'd0;
      r_last  <= 1'b0;
      r_idx   <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_in_type_ok) begin
              r_word  <= in_word_i;
              r_type  <= in_type_i;
              r_last  <= in_last_i;
              r_idx   <= 3'd0;
              r_state <= ST_EMIT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (w_word_done) begin
            r_idx <= 3'd0;
            if (w_accept && w_in_type_ok) begin
              r_word <= in_word_i;
              r_type <= in_type_i;
              r_last <= in_last_i;
            end else begin
              r_state <= ST_IDLE;
              r_err   <= w_accept;
            end
          end else if (out_ready_i) begin
            r_idx <= r_idx + 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 3'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
